// File: rtl/sat_alu_pkg.sv
// Shared definitions for the saturating add/subtract pipeline: op encoding,
// result flag bundle and the signed-overflow rule.
package sat_alu_pkg;

    localparam logic OP_SUB = 1'b0;
    localparam logic OP_ADD = 1'b1;

    typedef struct packed {
        logic zr;
        logic neg;
        logic ov;
    } flags_t;

    localparam flags_t FLAGS_RST = '{zr: 1'b1, neg: 1'b0, ov: 1'b0};

    // Overflow from operand signs and the sign of the wrapped result.
    function automatic logic ovf_detect(input logic op, input logic sign_a,
                                        input logic sign_b, input logic sign_r);
        if (op == OP_ADD)
            return (sign_a == sign_b) && (sign_r != sign_a);
        else
            return (sign_a != sign_b) && (sign_r != sign_a);
    endfunction

endpackage

// File: rtl/sat_flag_core.sv
// Combinational stage-2 logic: overflow detection, optional saturation and flags.
// Saturation is built only when SAT_ADDSUB_SATURATE_EN is defined.
module sat_flag_core
    import sat_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] raw,
    input  logic             sign_a,
    input  logic             sign_b,
    input  logic             op,
    output logic [WIDTH-1:0] res,
    output flags_t           flags
);

    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic ovf;

    always_comb begin
        ovf = ovf_detect(op, sign_a, sign_b, raw[WIDTH-1]);
        res = raw;
`ifdef SAT_ADDSUB_SATURATE_EN
        // The true result always carries the sign of in1 when overflow occurs.
        if (ovf)
            res = sign_a ? SAT_MIN : SAT_MAX;
`endif
        flags.ov  = ovf;
        flags.neg = res[WIDTH-1];
        flags.zr  = ~ovf & ~(|res);
    end

endmodule

// File: rtl/sat_addsub_pipe.sv
// Two-stage valid/ready pipelined add/subtract with overflow flags and sticky
// overflow. Define SAT_ADDSUB_SATURATE_EN to saturate overflowing results.
module sat_addsub_pipe
    import sat_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic             neg,
    output logic             ov,
    output logic             ov_sticky,
    input  logic             clr_sticky
);

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_raw_q, s1_raw_d;
    logic             s1_sa_q, s1_sa_d;
    logic             s1_sb_q, s1_sb_d;
    logic             s1_op_q, s1_op_d;

    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] out_q, out_d;
    flags_t           flags_q, flags_d;
    logic             sticky_q, sticky_d;

    logic             s1_load, s2_load;
    logic [WIDTH-1:0] core_res;
    flags_t           core_flags;

    sat_flag_core #(.WIDTH(WIDTH)) u_core (
        .raw    (s1_raw_q),
        .sign_a (s1_sa_q),
        .sign_b (s1_sb_q),
        .op     (s1_op_q),
        .res    (core_res),
        .flags  (core_flags)
    );

    always_comb begin
        s2_load    = ~s2_valid_q | out_ready;
        s1_load    = ~s1_valid_q | s2_load;

        s1_valid_d = s1_valid_q;
        s1_raw_d   = s1_raw_q;
        s1_sa_d    = s1_sa_q;
        s1_sb_d    = s1_sb_q;
        s1_op_d    = s1_op_q;
        s2_valid_d = s2_valid_q;
        out_d      = out_q;
        flags_d    = flags_q;

        if (s1_load) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_raw_d = (op == OP_ADD) ? (in1 + in2) : (in1 - in2);
                s1_sa_d  = in1[WIDTH-1];
                s1_sb_d  = in2[WIDTH-1];
                s1_op_d  = op;
            end
        end

        // Data registers only move on a real result so they hold while idle.
        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_d   = core_res;
                flags_d = core_flags;
            end
        end

        sticky_d = (sticky_q & ~clr_sticky) | (s2_load & s1_valid_q & core_flags.ov);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_raw_q   <= '0;
            s1_sa_q    <= 1'b0;
            s1_sb_q    <= 1'b0;
            s1_op_q    <= OP_SUB;
            s2_valid_q <= 1'b0;
            out_q      <= '0;
            flags_q    <= FLAGS_RST;
            sticky_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_raw_q   <= s1_raw_d;
            s1_sa_q    <= s1_sa_d;
            s1_sb_q    <= s1_sb_d;
            s1_op_q    <= s1_op_d;
            s2_valid_q <= s2_valid_d;
            out_q      <= out_d;
            flags_q    <= flags_d;
            sticky_q   <= sticky_d;
        end
    end

    assign in_ready  = s1_load;
    assign out_valid = s2_valid_q;
    assign out       = out_q;
    assign zr        = flags_q.zr;
    assign neg       = flags_q.neg;
    assign ov        = flags_q.ov;
    assign ov_sticky = sticky_q;

endmodule

// File: tb/tb_sat_addsub_pipe.sv
// Self-checking bench for sat_addsub_pipe: directed corner cases, stall/reset
// scenarios and randomized traffic against an integer-arithmetic reference.
module tb_sat_addsub_pipe;

    localparam int unsigned W = 16;

`ifdef SAT_ADDSUB_SATURATE_EN
    localparam logic [W-1:0] E_SUBMIN_OUT = 16'h8000;
    localparam logic         E_SUBMIN_NEG = 1'b1;
    localparam logic [W-1:0] E_ADDMAX_OUT = 16'h7FFF;
    localparam logic         E_ADDMAX_NEG = 1'b0;
`else
    // Without saturation the wrapped result is presented.
    localparam logic [W-1:0] E_SUBMIN_OUT = 16'h7FFF;
    localparam logic         E_SUBMIN_NEG = 1'b0;
    localparam logic [W-1:0] E_ADDMAX_OUT = 16'h8000;
    localparam logic         E_ADDMAX_NEG = 1'b1;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic         op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;
    logic         zr;
    logic         neg;
    logic         ov;
    logic         ov_sticky;
    logic         clr_sticky;

    always #5 clk = ~clk;

    sat_addsub_pipe #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in1        (in1),
        .in2        (in2),
        .op         (op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out        (out),
        .zr         (zr),
        .neg        (neg),
        .ov         (ov),
        .ov_sticky  (ov_sticky),
        .clr_sticky (clr_sticky)
    );

    typedef struct {
        logic [W-1:0] out;
        logic         zr;
        logic         neg;
        logic         ov;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_out    = 0;
    logic last_acc;
    logic chk_sticky;
    logic sticky_model;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   sa, sbv, r;
        int   maxv, minv;
        maxv = (1 << (W - 1)) - 1;
        minv = -(1 << (W - 1));
        sa   = $signed(a);
        sbv  = $signed(b);
        r    = o ? (sa + sbv) : (sa - sbv);
        e.ov = (r > maxv) || (r < minv);
`ifdef SAT_ADDSUB_SATURATE_EN
        if (r > maxv) r = maxv;
        else if (r < minv) r = minv;
`endif
        e.out = r[W-1:0];
        e.neg = e.out[W-1];
        e.zr  = !e.ov && (e.out == '0);
        return e;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom % 5)
            0: return 16'h8000;
            1: return 16'h7FFF;
            2: return W'($urandom % 4);
            3: return 16'hFFFF - W'($urandom % 4);
            default: return W'($urandom);
        endcase
    endfunction

    // Samples the transfers that the coming rising edge performs, then
    // returns #1 after that edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        last_acc = 1'b0;
        if (!rst) begin
            if (out_valid && out_ready) begin
                n_out++;
                if (sb_q.size() == 0) begin
                    check("spurious_out", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("out", 32'(out), 32'(e.out));
                    check("zr", 32'(zr), 32'(e.zr));
                    check("neg", 32'(neg), 32'(e.neg));
                    check("ov", 32'(ov), 32'(e.ov));
                    if (chk_sticky) begin
                        check("sticky_run", 32'(ov_sticky), 32'(sticky_model | e.ov));
                        sticky_model = sticky_model | e.ov;
                    end
                end
            end
            if (in_valid && in_ready) begin
                sb_q.push_back(model(op, in1, in2));
                last_acc = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
        in_valid = 1'b1;
        op       = o;
        in1      = a;
        in2      = b;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (last_acc) break;
        end
        check("offer_accept", 32'(last_acc), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic do_op(input string tag, input logic o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] eout,
                         input logic eov, input logic ezr, input logic eneg);
        in_valid  = 1'b1;
        op        = o;
        in1       = a;
        in2       = b;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check({tag, "_lat1_valid"}, 32'(out_valid), 32'd0);
        tick();
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_out"}, 32'(out), 32'(eout));
        check({tag, "_ov"}, 32'(ov), 32'(eov));
        check({tag, "_zr"}, 32'(zr), 32'(ezr));
        check({tag, "_neg"}, 32'(neg), 32'(eneg));
    endtask

    initial begin
        exp_t ea;
        int   nbase;
        rst          = 1'b1;
        in_valid     = 1'b0;
        in1          = '0;
        in2          = '0;
        op           = 1'b0;
        out_ready    = 1'b0;
        clr_sticky   = 1'b0;
        chk_sticky   = 1'b0;
        sticky_model = 1'b0;
        last_acc     = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out", 32'(out), 32'd0);
        check("rst_zr", 32'(zr), 32'd1);
        check("rst_neg", 32'(neg), 32'd0);
        check("rst_ov", 32'(ov), 32'd0);
        check("rst_sticky", 32'(ov_sticky), 32'd0);
        rst = 1'b0;
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd1);

        do_op("sub_min", 1'b0, 16'h8000, 16'h0001, E_SUBMIN_OUT, 1'b1, 1'b0, E_SUBMIN_NEG);
        check("sub_min_sticky", 32'(ov_sticky), 32'd1);
        do_op("add_max", 1'b1, 16'h7FFF, 16'h0001, E_ADDMAX_OUT, 1'b1, 1'b0, E_ADDMAX_NEG);
        do_op("sub_eq", 1'b0, 16'h0005, 16'h0005, 16'h0000, 1'b0, 1'b1, 1'b0);
        do_op("add_wrap0", 1'b1, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b1, 1'b0);
        do_op("sub_negres", 1'b0, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b0, 1'b1);

        // Clear while idle, then clear coinciding with an overflowing load.
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        check("clr_sticky", 32'(ov_sticky), 32'd0);
        in_valid = 1'b1;
        op       = 1'b1;
        in1      = 16'h7FFF;
        in2      = 16'h7FFF;
        tick();
        in_valid   = 1'b0;
        clr_sticky = 1'b1;
        tick();
        check("set_wins_ov", 32'(ov), 32'd1);
        check("set_wins_sticky", 32'(ov_sticky), 32'd1);
        tick();
        clr_sticky = 1'b0;
        check("clr_next_sticky", 32'(ov_sticky), 32'd0);

        // Back-pressure: two accepted, third blocked until out_ready rises.
        out_ready = 1'b0;
        ea = model(1'b1, 16'h1234, 16'h0101);
        offer(1'b1, 16'h1234, 16'h0101);
        offer(1'b0, 16'h0010, 16'h0020);
        in_valid = 1'b1;
        op       = 1'b1;
        in1      = 16'h4000;
        in2      = 16'h4000;
        check("stall_in_ready", 32'(in_ready), 32'd0);
        tick();
        tick();
        check("stall_in_ready_hold", 32'(in_ready), 32'd0);
        check("stall_out_valid", 32'(out_valid), 32'd1);
        check("stall_out_first", 32'(out), 32'(ea.out));
        nbase     = n_out;
        out_ready = 1'b1;
        offer(1'b1, 16'h4000, 16'h4000);
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) tick();
        check("stall_drained", 32'(n_out - nbase), 32'd3);

        // Reset with both stages full.
        out_ready = 1'b0;
        offer(1'b1, 16'h7FFF, 16'h0002);
        offer(1'b0, 16'h0100, 16'h0001);
        check("full_out_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_out", 32'(out), 32'd0);
        check("async_rst_zr", 32'(zr), 32'd1);
        check("async_rst_sticky", 32'(ov_sticky), 32'd0);
        sb_q.delete();
        tick();
        tick();
        rst       = 1'b0;
        out_ready = 1'b1;
        nbase     = n_out;
        repeat (6) tick();
        check("no_stale_out", 32'(n_out - nbase), 32'd0);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Randomized traffic with random back-pressure.
        clr_sticky = 1'b1;
        tick();
        clr_sticky   = 1'b0;
        sticky_model = 1'b0;
        chk_sticky   = 1'b1;
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom % 4) != 0;
            op        = 1'($urandom % 2);
            in1       = pick();
            in2       = pick();
            out_ready = ($urandom % 3) != 0;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) tick();
        check("rand_drained", 32'(sb_q.size()), 32'd0);
        check("rand_final_valid", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
